// File: rtl/hit_capture.sv
// Play-mode front end: key conditioning, octave tracking and note timing.
// A single held key produces one hit event with its length on release.
module hit_capture #(
    parameter int NOTE_KEYS       = 7,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int BEAT_CYCLES     = 5000000,
    parameter int CLOCK_BITS      = 32,
    parameter int OCT_MAX         = 2,
    parameter int OCT_DEFAULT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NOTE_KEYS-1:0]  note_key,
    input  logic                  oct_up,
    input  logic                  oct_down,
    input  logic [CLOCK_BITS-1:0] system_clock,
    output logic                  hit_valid,
    output logic [CLOCK_BITS-1:0] hit_clock,
    output logic [1:0]            hit_octave,
    output logic [2:0]            hit_note,
    output logic [2:0]            hit_length,
    output logic [1:0]            octave,
    output logic                  busy
);

    localparam int NI = NOTE_KEYS + 2;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BEAT_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [1:0] OCT_TOP = 2'(OCT_MAX);
    localparam logic [1:0] OCT_DEF = 2'(OCT_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        EMIT
    } state_t;

    state_t state;

    logic [NI-1:0] raw;
    logic [NI-1:0] sync1;
    logic [NI-1:0] sync2;
    logic [NI-1:0] deb;
    logic [NI-1:0] flip;
    logic [DW-1:0] cnt [NI];

    logic [NOTE_KEYS-1:0] note_deb;
    logic [NOTE_KEYS-1:0] cap_bit;
    logic [2:0]           note_idx;
    logic                 one_hot;
    logic                 up_rise;
    logic                 down_rise;

    logic [2:0]            cap_note;
    logic [CLOCK_BITS-1:0] cap_clock;
    logic [1:0]            cap_octave;
    logic [BW-1:0]         hold_cnt;
    logic [2:0]            units;

    assign raw = {oct_down, oct_up, note_key};

    // A debounced bit flips on the last of N disagreeing samples.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            flip[i] = (sync2[i] != deb[i]) && (cnt[i] == DEB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < NI; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NI; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    cnt[i] <= '0;
                    deb[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign note_deb  = deb[NOTE_KEYS-1:0];
    assign one_hot   = $onehot(note_deb);
    assign up_rise   = flip[NOTE_KEYS] & sync2[NOTE_KEYS];
    assign down_rise = flip[NOTE_KEYS+1] & sync2[NOTE_KEYS+1];

    always_comb begin
        note_idx = '0;
        for (int i = 0; i < NOTE_KEYS; i++) begin
            if (note_deb[i]) begin
                note_idx = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hit_valid  <= 1'b0;
            hit_clock  <= '0;
            hit_octave <= OCT_DEF;
            hit_note   <= '0;
            hit_length <= '0;
            octave     <= OCT_DEF;
            busy       <= 1'b0;
            cap_bit    <= '0;
            cap_note   <= '0;
            cap_clock  <= '0;
            cap_octave <= OCT_DEF;
            hold_cnt   <= '0;
            units      <= '0;
        end else if (!en) begin
            state     <= IDLE;
            hit_valid <= 1'b0;
            busy      <= 1'b0;
            octave    <= OCT_DEF;
        end else begin
            hit_valid <= 1'b0;
            if (up_rise && !down_rise && octave != OCT_TOP) begin
                octave <= octave + 2'd1;
            end else if (down_rise && !up_rise && octave != 2'd0) begin
                octave <= octave - 2'd1;
            end
            unique case (state)
                IDLE: begin
                    if (one_hot) begin
                        cap_bit    <= note_deb;
                        cap_note   <= note_idx;
                        cap_clock  <= system_clock;
                        cap_octave <= octave;
                        hold_cnt   <= '0;
                        units      <= 3'd1;
                        busy       <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (note_deb != cap_bit) begin
                        hit_note   <= cap_note;
                        hit_clock  <= cap_clock;
                        hit_octave <= cap_octave;
                        hit_length <= units;
                        hit_valid  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= EMIT;
                    end else if (hold_cnt == BEAT_LAST) begin
                        hold_cnt <= '0;
                        if (units != 3'd7) begin
                            units <= units + 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_capture.sv
// Directed bench for hit_capture with short debounce and beat lengths.
// Table-driven note holds plus hand sequences for octave, chords, en and rst.
module tb_hit_capture;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [6:0]  note_key;
    logic        oct_up;
    logic        oct_down;
    logic [31:0] sys_clk = 32'd1000;
    logic        hit_valid;
    logic [31:0] hit_clock;
    logic [1:0]  hit_octave;
    logic [2:0]  hit_note;
    logic [2:0]  hit_length;
    logic [1:0]  octave;
    logic        busy;

    int errors = 0;
    int checks = 0;

    hit_capture #(
        .DEBOUNCE_CYCLES(4),
        .BEAT_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .note_key(note_key),
        .oct_up(oct_up),
        .oct_down(oct_down),
        .system_clock(sys_clk),
        .hit_valid(hit_valid),
        .hit_clock(hit_clock),
        .hit_octave(hit_octave),
        .hit_note(hit_note),
        .hit_length(hit_length),
        .octave(octave),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) sys_clk <= sys_clk + 32'd1;

    typedef struct {
        logic [6:0] key;
        int         hold;
        int         note;
        int         len;
    } vec_t;

    vec_t tv [6];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_hit(output int pulses, output int nt, output int ln,
                            output int oc, output longint ck);
        pulses = 0;
        nt = -1;
        ln = -1;
        oc = -1;
        ck = -1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (hit_valid) begin
                if (pulses == 0) begin
                    nt = int'(hit_note);
                    ln = int'(hit_length);
                    oc = int'(hit_octave);
                    ck = longint'(hit_clock);
                end
                pulses++;
            end
        end
    endtask

    task automatic run_note(input string nm, input logic [6:0] key,
                            input int hold, input int nt, input int ln,
                            input int oc);
        int p, gn, gl, go;
        longint gc, s0;
        s0 = longint'(sys_clk);
        note_key = key;
        step(hold);
        note_key = '0;
        wait_hit(p, gn, gl, go, gc);
        chk({nm, " pulses"}, p, 1);
        chk({nm, " note"}, gn, nt);
        chk({nm, " length"}, gl, ln);
        chk({nm, " octave"}, go, oc);
        chk({nm, " clock"}, gc, s0 + LAT);
        chk({nm, " held note"}, hit_note, nt);
        chk({nm, " busy after"}, busy, 0);
    endtask

    task automatic press(input bit up);
        if (up) oct_up = 1'b1;
        else oct_down = 1'b1;
        step(8);
        oct_up = 1'b0;
        oct_down = 1'b0;
        step(8);
    endtask

    initial begin
        int p, gn, gl, go, seen_b, seen_v, t1, t2;
        longint gc;

        tv[0] = '{7'b0000100, 25, 3, 3};
        tv[1] = '{7'b0000001, 5, 1, 1};
        tv[2] = '{7'b1000000, 12, 7, 2};
        tv[3] = '{7'b0010000, 21, 5, 3};
        tv[4] = '{7'b0001000, 55, 4, 6};
        tv[5] = '{7'b0000010, 200, 2, 7};

        rst = 1'b1;
        en = 1'b1;
        note_key = '0;
        oct_up = 1'b0;
        oct_down = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst hit_valid", hit_valid, 0);
        chk("rst hit_clock", hit_clock, 0);
        chk("rst hit_note", hit_note, 0);
        chk("rst hit_length", hit_length, 0);
        chk("rst hit_octave", hit_octave, 1);
        chk("rst octave", octave, 1);
        chk("rst busy", busy, 0);
        step(2);

        run_note("first", 7'b0000100, 25, 3, 3, 1);

        press(1'b1);
        chk("oct up 1", octave, 2);
        press(1'b1);
        chk("oct up 2", octave, 2);
        press(1'b1);
        chk("oct up 3", octave, 2);
        run_note("oct2 note", 7'b1000000, 15, 7, 2, 2);
        press(1'b0);
        chk("oct down", octave, 1);

        for (int i = 0; i < 6; i++) begin
            run_note($sformatf("vec%0d", i), tv[i].key, tv[i].hold,
                     tv[i].note, tv[i].len, 1);
        end

        note_key = 7'b0000100;
        step(10);
        oct_up = 1'b1;
        step(8);
        oct_up = 1'b0;
        step(12);
        note_key = '0;
        wait_hit(p, gn, gl, go, gc);
        chk("mid oct pulses", p, 1);
        chk("mid oct hit_octave", go, 1);
        chk("mid oct live", octave, 2);
        press(1'b0);
        chk("mid oct restore", octave, 1);

        seen_b = 0;
        note_key = 7'b0000001;
        step(3);
        note_key = '0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (busy) seen_b++;
        end
        chk("bounce busy", seen_b, 0);

        seen_b = 0;
        seen_v = 0;
        note_key = 7'b0000011;
        for (int i = 0; i < 35; i++) begin
            if (i == 20) note_key = '0;
            step(1);
            if (busy) seen_b++;
            if (hit_valid) seen_v++;
        end
        chk("chord busy", seen_b, 0);
        chk("chord hit", seen_v, 0);

        t1 = -1;
        t2 = -1;
        gn = -1;
        note_key = 7'b0000010;
        step(15);
        note_key = 7'b0010000;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (hit_valid && t1 < 0) begin
                t1 = i;
                gn = int'(hit_note);
            end else if (t1 >= 0 && t2 < 0 && busy) begin
                t2 = i;
            end
        end
        chk("switch first note", gn, 2);
        chk("switch pulse seen", t1 >= 0, 1);
        chk("switch recapture gap", t2 - t1, 2);
        note_key = '0;
        wait_hit(p, gn, gl, go, gc);
        chk("switch second pulses", p, 1);
        chk("switch second note", gn, 5);

        press(1'b1);
        chk("en oct pre", octave, 2);
        note_key = 7'b0001000;
        step(15);
        chk("en busy pre", busy, 1);
        en = 1'b0;
        step(1);
        chk("en busy off", busy, 0);
        chk("en octave", octave, 1);
        note_key = '0;
        seen_v = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (hit_valid) seen_v++;
        end
        chk("en no hit", seen_v, 0);
        en = 1'b1;
        step(2);
        chk("en back octave", octave, 1);
        chk("en back busy", busy, 0);

        press(1'b1);
        note_key = 7'b0100000;
        step(15);
        chk("rst busy pre", busy, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid rst busy", busy, 0);
        chk("mid rst hit_valid", hit_valid, 0);
        chk("mid rst hit_note", hit_note, 0);
        chk("mid rst hit_length", hit_length, 0);
        chk("mid rst hit_clock", hit_clock, 0);
        chk("mid rst hit_octave", hit_octave, 1);
        chk("mid rst octave", octave, 1);
        note_key = '0;
        step(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hit_capture.md
Name: hit_capture

Overview:
Upstream front end of the play-mode datapath. It debounces the seven note keys and the octave up/down buttons, tracks the current octave, and times how long a single note key is held. On release it emits a one-cycle hit event carrying note, octave, quantised length and press timestamp. The play-mode scorer and the sound block consume this event.

Parameters:
NOTE_KEYS, 7, number of note keys; key bit i maps to note i+1
DEBOUNCE_CYCLES, 200000, consecutive identical samples required before a debounced input changes
BEAT_CYCLES, 5000000, clk cycles per length unit
CLOCK_BITS, 32, width of the system timestamp
OCT_MAX, 2, highest octave index
OCT_DEFAULT, 1, octave after reset or while disabled

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  play mode active
note_key  in  NOTE_KEYS  raw note switches, 1 = pressed
oct_up  in  1  raw octave-up button
oct_down  in  1  raw octave-down button
system_clock  in  CLOCK_BITS  free-running game timestamp
hit_valid  out  1  one-cycle strobe: hit fields are valid
hit_clock  out  CLOCK_BITS  system_clock sampled at press capture
hit_octave  out  2  octave at press capture
hit_note  out  3  1..7; 0 = none
hit_length  out  3  held length in units, 1..7
octave  out  2  live octave index
busy  out  1  high while a key is being timed

Behaviour:
- Reset is synchronous and active-high, on clk only.
- Reset values: hit_valid, hit_clock, hit_note, hit_length, busy = 0; hit_octave = octave = OCT_DEFAULT; state = IDLE; all debounce counters and debounced values = 0.
- Input conditioning: each of the 9 raw inputs passes through a 2-FF synchroniser, then its own debounce counter.
  - The debounced value takes the synchronised value after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  - Any agreeing sample clears that counter.
- Octave control:
  - A debounced rising edge of oct_up increments octave, saturating at OCT_MAX.
  - A debounced rising edge of oct_down decrements octave, saturating at 0.
  - Both edges in the same cycle: no change.
  - Octave changes during HOLD do not affect the captured hit_octave.
- FSM states: IDLE, HOLD, EMIT.
- IDLE:
  - If the debounced note vector is exactly one-hot, latch note = index+1, cap_clock = system_clock, cap_octave = octave, hold_cnt = 0, units = 1, and go to HOLD. busy = 1 from the next cycle.
  - A zero or multi-bit vector keeps the FSM in IDLE; chords are ignored.
- HOLD:
  - hold_cnt increments each cycle.
  - When hold_cnt reaches BEAT_CYCLES-1, it wraps to 0 and units increments, saturating at 7. hold_cnt keeps wrapping after saturation.
  - Leave HOLD for EMIT when the debounced vector no longer equals the captured one-hot bit (release, different key, or chord).
- EMIT:
  - Registered outputs update: hit_note, hit_clock, hit_octave, hit_length = units, hit_valid = 1 for exactly this cycle, busy = 0.
  - Next state is IDLE.
  - If a different single key is already held, IDLE captures it on the following cycle. Latency from detected change to the next capture is 2 cycles.
- Hit fields hold their values until the next EMIT; only hit_valid pulses.
- Length rule: hit_length = min(floor(held_cycles / BEAT_CYCLES) + 1, 7). held_cycles counts HOLD cycles.
- en low (any state, including mid-HOLD):
  - FSM returns to IDLE next cycle and no event is emitted; the abandoned note is discarded.
  - busy = 0, hit_valid = 0, octave = OCT_DEFAULT.
  - Debouncers keep running.
- rst has priority over en.
- system_clock wrap-around is not handled here; it is passed through unmodified.

Test Plan:
(Bench overrides: DEBOUNCE_CYCLES=4, BEAT_CYCLES=10.)
1. Reset → all outputs 0, octave=1. Hold note_key=7'b0000100 for 25 cycles, then release → exactly one hit_valid pulse; hit_note=3, hit_octave=1, hit_length=3; hit_clock equals system_clock at the capture cycle.
2. Three oct_up presses, each held 8 cycles with 8-cycle gaps → octave 2, 2, 2 (saturates). Then one oct_down → 1. Next note → hit_octave=1.
3. note_key bit0 pulses high for 3 cycles (bounce) → no capture, busy stays 0. Chord 7'b0000011 held 20 cycles → no hit_valid.
4. Hold bit1 for 15 cycles, then switch directly to bit4 → hit_note=2 pulse, then a second capture 2 cycles later. Releasing bit4 gives hit_note=5.
5. Hold key for 200 cycles → hit_length=7 (saturated).
6. Deassert en mid-HOLD → no hit_valid, busy=0 next cycle, octave=1. Assert rst mid-HOLD → all outputs reset next cycle.
